// File: rtl/timing_ring_controller_if.sv
// timing_ring_controller_if: run-control and trigger-bank signals of the timing ring controller
interface timing_ring_controller_if #(parameter int NPOS = 10);
  logic            i_start;
  logic            i_stop;
  logic            i_single;
  logic            i_hold;
  logic [NPOS-1:0] i_trig_q;
  logic [NPOS-1:0] o_ring;
  logic [NPOS-1:0] o_gate_set;
  logic [NPOS-1:0] o_gate_clr;
  logic            o_ac_set;
  logic [NPOS-1:0] o_rst_clr_n;
  logic            o_running;
  logic            o_cycle_end;
  logic            o_fault;
  modport master (
    output i_start, i_stop, i_single, i_hold, i_trig_q,
    input  o_ring, o_gate_set, o_gate_clr, o_ac_set, o_rst_clr_n, o_running, o_cycle_end, o_fault
  );
  modport slave (
    input  i_start, i_stop, i_single, i_hold, i_trig_q,
    output o_ring, o_gate_set, o_gate_clr, o_ac_set, o_rst_clr_n, o_running, o_cycle_end, o_fault
  );
endinterface

// File: rtl/timing_ring_controller.sv
// timing_ring_controller: sequences a one-hot trigger ring with start/stop/single/hold control and ring checking
module timing_ring_controller #(
  parameter int NPOS   = 10,
  parameter bit CHK_EN = 1'b1
) (
  input logic                      x,
  input logic                      rst,
  timing_ring_controller_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_FINISH} state_t;
  state_t          r_state, w_state;
  logic [NPOS-1:0] r_ring, r_gate_set, r_gate_clr, r_rst_clr_n;
  logic [NPOS-1:0] w_ring, w_gate_set, w_gate_clr, w_rst_clr_n, w_rot;
  logic            r_ac_set, r_running, r_cycle_end, r_fault, r_stop, r_start, r_chk;
  logic            w_ac_set, w_running, w_fault, w_stop, w_chk, w_frz;
  logic            w_bad, w_adv, w_end, w_done;
  assign w_bad  = CHK_EN && r_chk && (bus.i_trig_q != r_ring);
  assign w_adv  = r_state == S_RUN && !bus.i_hold && !w_bad;
  assign w_end  = w_adv && r_ring[NPOS-1];
  assign w_done = w_end && (bus.i_single || r_stop || bus.i_stop);
  assign w_rot  = {r_ring[NPOS-2:0], r_ring[NPOS-1]};
  always_ff @(posedge x) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ring      <= '0;
      r_gate_set  <= '0;
      r_gate_clr  <= '0;
      r_ac_set    <= 1'b0;
      r_rst_clr_n <= '1;
      r_running   <= 1'b0;
      r_cycle_end <= 1'b0;
      r_fault     <= 1'b0;
      r_stop      <= 1'b0;
      r_start     <= 1'b0;
      r_chk       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_ring      <= w_ring;
      r_gate_set  <= w_gate_set;
      r_gate_clr  <= w_gate_clr;
      r_ac_set    <= w_ac_set;
      r_rst_clr_n <= w_rst_clr_n;
      r_running   <= w_running;
      r_cycle_end <= w_end;
      r_fault     <= w_fault;
      r_stop      <= w_stop;
      r_start     <= bus.i_start && r_state == S_IDLE;
      r_chk       <= w_chk;
    end
  end
  always_comb begin
    w_state = r_state;
    unique case (r_state)
      S_IDLE:   w_state = r_start ? S_CLEAR : S_IDLE;
      S_CLEAR:  w_state = S_RUN;
      S_RUN:    w_state = (w_bad || w_done) ? S_FINISH : S_RUN;
      S_FINISH: w_state = S_IDLE;
    endcase
  end
  // a held ring keeps its gates; leaving RUN drops everything to zero
  always_comb begin
    w_frz       = r_state == S_RUN && bus.i_hold;
    w_ring      = w_state != S_RUN ? '0 : r_state == S_CLEAR ? NPOS'(1) : w_adv ? w_rot : r_ring;
    w_gate_clr  = w_state != S_RUN ? '0 : w_frz ? r_gate_clr : w_ring;
    w_gate_set  = w_state != S_RUN ? '0 : w_frz ? r_gate_set : {w_ring[NPOS-2:0], w_ring[NPOS-1]};
    w_ac_set    = w_state == S_RUN && !bus.i_hold;
    w_rst_clr_n = w_state == S_CLEAR ? '0 : '1;
    w_running   = w_state != S_IDLE;
    w_fault     = r_fault || w_bad;
    w_chk       = w_adv && w_state == S_RUN;
    w_stop      = r_state == S_FINISH ? 1'b0 :
                  r_stop || (bus.i_stop && (r_state != S_IDLE || bus.i_start || r_start));
  end
  assign bus.o_ring      = r_ring;
  assign bus.o_gate_set  = r_gate_set;
  assign bus.o_gate_clr  = r_gate_clr;
  assign bus.o_ac_set    = r_ac_set;
  assign bus.o_rst_clr_n = r_rst_clr_n;
  assign bus.o_running   = r_running;
  assign bus.o_cycle_end = r_cycle_end;
  assign bus.o_fault     = r_fault;
  a_ring_onehot: assert property (@(posedge x) disable iff (rst)
    (r_state == S_RUN) ? $onehot(r_ring) : (r_ring == '0));
endmodule
